fetch_responder: RTL and testbench

- Sits at the other end of the fetch unit's PC interface.
- Consumes the current PC, fetches the instruction word from an external instruction-memory port, and decodes JAL.
- Drives the fetch unit's stall_en, jal_en and imm inputs so the PC advances exactly once per returned instruction.
- Also presents the fetched instruction to decode and flags misaligned or timed-out fetches.

---
 rtl/fetch_responder_pkg.sv | 20 ++
 rtl/fetch_responder_jal.sv | 23 ++
 rtl/fetch_responder.sv | 109 ++++++++++
 tb/tb_fetch_responder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_responder_pkg.sv
// Shared definitions for the fetch responder and the JAL decoder it shares with decode.
// Opcode/NOP constants, the FSM state type and J-immediate bit gathering.
package fetch_responder_pkg;

  localparam logic [6:0]  OPC_JAL  = 7'b1101111;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    RESP  = 2'd2,
    FAULT = 2'd3
  } state_e;

  // Reassembles the scrambled J-type immediate; the result is imm[20:0] with imm[0]=0.
  function automatic logic [20:0] j_imm(input logic [31:12] hi);
    return {hi[31], hi[19:12], hi[20], hi[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_responder_jal.sv
// Combinational JAL detector: flags the JAL opcode and produces its sign-extended offset.
// The offset is forced to zero for any other instruction so callers can use it unqualified.
module jal_decoder
  import fetch_responder_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] inst_i,
  output logic            jal_en_o,
  output logic [XLEN-1:0] imm_o
);

  logic [20:0] imm_raw;
  logic        unused_rd;

  assign jal_en_o = (inst_i[6:0] == OPC_JAL);
  assign imm_raw  = j_imm(inst_i[31:12]);
  assign imm_o    = jal_en_o ? {{(XLEN-21){imm_raw[20]}}, imm_raw} : '0;

  // The link register does not influence the jump target.
  assign unused_rd = ^inst_i[11:7];

endmodule

// File: rtl/fetch_responder.sv
// PC-interface responder: fetches the word at io_pc, decodes JAL and releases the PC
// for exactly one cycle per returned instruction. Misaligned PCs and timeouts fault.
module fetch_responder
  import fetch_responder_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [XLEN-1:0]  io_pc,
  output logic             io_mem_req_valid,
  input  logic             io_mem_req_ready,
  output logic [XLEN-1:0]  io_mem_req_addr,
  input  logic             io_mem_resp_valid,
  input  logic [XLEN-1:0]  io_mem_resp_data,
  output logic             io_stall_en,
  output logic             io_jal_en,
  output logic [XLEN-1:0]  io_imm,
  output logic [XLEN-1:0]  io_inst,
  output logic             io_inst_valid,
  output logic             io_fault,
  output logic [CNT_W-1:0] io_stall_cnt
);

  localparam int             TMO_W    = 16;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_e            state_q;
  logic [TMO_W-1:0]  tmo_q;
  logic [XLEN-1:0]   inst_q;
  logic              fault_q;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  stall_cnt_d;

  logic              misaligned;
  logic              in_resp;
  logic              dec_jal;
  logic [XLEN-1:0]   dec_imm;

  assign misaligned = (io_pc[1:0] != 2'b00);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= REQ;
      tmo_q   <= '0;
      inst_q  <= XLEN'(NOP_INST);
      fault_q <= 1'b0;
    end else begin
      unique case (state_q)
        REQ: begin
          if (misaligned) begin
            state_q <= FAULT;
            fault_q <= 1'b1;
          end else if (io_mem_req_ready) begin
            state_q <= WAIT;
            tmo_q   <= '0;
          end
        end
        WAIT: begin
          // A response arriving on the final timeout cycle still wins.
          if (io_mem_resp_valid) begin
            inst_q  <= io_mem_resp_data;
            state_q <= RESP;
          end else if (tmo_q == TMO_LAST) begin
            state_q <= FAULT;
            fault_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        RESP:    state_q <= REQ;
        default: state_q <= FAULT;
      endcase
    end
  end

  assign stall_cnt_d = (io_stall_en && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1 : stall_cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  jal_decoder #(
    .XLEN(XLEN)
  ) u_jal_decoder (
    .inst_i   (inst_q),
    .jal_en_o (dec_jal),
    .imm_o    (dec_imm)
  );

  // Outputs are state-decoded; reset forces the safe stalled/idle values immediately.
  assign in_resp          = !reset && (state_q == RESP);
  assign io_mem_req_valid = !reset && (state_q == REQ) && !misaligned;
  assign io_mem_req_addr  = io_pc;
  assign io_stall_en      = reset || (state_q != RESP);
  assign io_inst_valid    = in_resp;
  assign io_jal_en        = in_resp && dec_jal;
  assign io_imm           = in_resp ? dec_imm : '0;
  assign io_inst          = inst_q;
  assign io_fault         = fault_q;
  assign io_stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_fetch_responder.sv
// Scoreboarded bench: each accepted fetch pushes its expected decode, which a monitor
// pops when io_inst_valid rises; scenario tasks check handshakes, PC advance and faults.
module tb_fetch_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] io_pc;
  logic        io_mem_req_valid;
  logic        io_mem_req_ready;
  logic [31:0] io_mem_req_addr;
  logic        io_mem_resp_valid;
  logic [31:0] io_mem_resp_data;
  logic        io_stall_en;
  logic        io_jal_en;
  logic [31:0] io_imm;
  logic [31:0] io_inst;
  logic        io_inst_valid;
  logic        io_fault;
  logic [31:0] io_stall_cnt;

  always #5 clock = ~clock;

  fetch_responder #(.XLEN(32), .TIMEOUT(4), .CNT_W(32)) dut (
    .clock             (clock),
    .reset             (reset),
    .io_pc             (io_pc),
    .io_mem_req_valid  (io_mem_req_valid),
    .io_mem_req_ready  (io_mem_req_ready),
    .io_mem_req_addr   (io_mem_req_addr),
    .io_mem_resp_valid (io_mem_resp_valid),
    .io_mem_resp_data  (io_mem_resp_data),
    .io_stall_en       (io_stall_en),
    .io_jal_en         (io_jal_en),
    .io_imm            (io_imm),
    .io_inst           (io_inst),
    .io_inst_valid     (io_inst_valid),
    .io_fault          (io_fault),
    .io_stall_cnt      (io_stall_cnt)
  );

  typedef struct {
    logic [31:0] inst;
    logic        jal;
    logic [31:0] imm;
  } exp_t;

  exp_t sb_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   exp_stall = 0;

  function automatic logic model_jal(input logic [31:0] w);
    return w[6:0] == 7'h6F;
  endfunction

  function automatic logic [31:0] model_imm(input logic [31:0] w);
    logic signed [19:0] f;
    int v;
    f = {w[31], w[19:12], w[20], w[30:21]};
    v = int'(f) * 2;
    return v;
  endfunction

  // Scoreboard monitor: sampled 1 time unit after the rising edge.
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (io_inst_valid) begin
      if (sb_q.size() == 0) begin
        total_cnt++;
        $display("FAIL sb_unexpected: inst_valid=1 inst=%h, required no output", io_inst);
      end else begin
        e = sb_q.pop_front();
        total_cnt++; if (io_inst !== e.inst) $display("FAIL sb_inst: got %h want %h", io_inst, e.inst); else pass_cnt++;
        total_cnt++; if (io_jal_en !== e.jal) $display("FAIL sb_jal_en: got %b want %b (inst %h)", io_jal_en, e.jal, e.inst); else pass_cnt++;
        total_cnt++; if (io_imm !== e.imm) $display("FAIL sb_imm: got %h want %h (inst %h)", io_imm, e.imm, e.inst); else pass_cnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Memory + fetch-unit stimulus for one instruction, starting at a negedge in REQ.
  // Records per-cycle traces (oldest cycle in the highest bit) and advances io_pc like the fetch unit.
  task automatic drive_fetch(input logic [31:0] data, input int rdy_wait, input int rsp_wait,
                             output logic [15:0] stall_tr, output logic [15:0] req_tr,
                             output logic [15:0] vld_tr, output logic addr_ok);
    exp_t e;
    logic [31:0] nxt;
    int n;
    n = rdy_wait + rsp_wait + 3;
    stall_tr = '0; req_tr = '0; vld_tr = '0; addr_ok = 1'b1; nxt = io_pc;
    e.inst = data;
    e.jal  = model_jal(data);
    e.imm  = e.jal ? model_imm(data) : 32'd0;
    for (int c = 0; c < n; c++) begin
      io_mem_req_ready  = (c == rdy_wait);
      io_mem_resp_valid = (c == rdy_wait + 1 + rsp_wait);
      io_mem_resp_data  = io_mem_resp_valid ? data : $urandom;
      if (c == rdy_wait) sb_q.push_back(e);
      #1;
      stall_tr = {stall_tr[14:0], io_stall_en};
      req_tr   = {req_tr[14:0], io_mem_req_valid};
      vld_tr   = {vld_tr[14:0], io_inst_valid};
      if (io_mem_req_valid && (io_mem_req_addr !== io_pc)) addr_ok = 1'b0;
      if (!io_stall_en) nxt = io_jal_en ? io_pc + io_imm : io_pc + 32'd4;
      @(negedge clock);
    end
    io_mem_req_ready  = 1'b0;
    io_mem_resp_valid = 1'b0;
    io_pc = nxt;
    exp_stall += n - 1;
  endtask

  task automatic test_reset();
    reset = 1'b1; io_pc = 32'h0; io_mem_req_ready = 1'b1; io_mem_resp_valid = 1'b1;
    io_mem_resp_data = 32'h0080006F;
    repeat (3) @(negedge clock);
    total_cnt++; if (io_stall_en !== 1'b1) $display("FAIL reset_stall_en: got %b want 1", io_stall_en); else pass_cnt++;
    total_cnt++; if (io_jal_en !== 1'b0) $display("FAIL reset_jal_en: got %b want 0", io_jal_en); else pass_cnt++;
    total_cnt++; if (io_imm !== 32'h0) $display("FAIL reset_imm: got %h want 0", io_imm); else pass_cnt++;
    total_cnt++; if (io_inst_valid !== 1'b0) $display("FAIL reset_inst_valid: got %b want 0", io_inst_valid); else pass_cnt++;
    total_cnt++; if (io_mem_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %b want 0", io_mem_req_valid); else pass_cnt++;
    total_cnt++; if (io_fault !== 1'b0) $display("FAIL reset_fault: got %b want 0", io_fault); else pass_cnt++;
    total_cnt++; if (io_stall_cnt !== 32'h0) $display("FAIL reset_stall_cnt: got %0d want 0", io_stall_cnt); else pass_cnt++;
    total_cnt++; if (io_inst !== 32'h0000_0013) $display("FAIL reset_inst: got %h want 00000013", io_inst); else pass_cnt++;
    reset = 1'b0; io_mem_req_ready = 1'b0; io_mem_resp_valid = 1'b0; exp_stall = 0;
    #1;
    total_cnt++; if (io_mem_req_valid !== 1'b1) $display("FAIL post_reset_req_valid: got %b want 1", io_mem_req_valid); else pass_cnt++;
    total_cnt++; if (io_mem_req_addr !== 32'h0) $display("FAIL post_reset_addr: got %h want 0", io_mem_req_addr); else pass_cnt++;
  endtask

  task automatic test_nop();
    logic [15:0] st, rq, vl; logic ok;
    drive_fetch(32'h0000_0013, 0, 0, st, rq, vl, ok);
    total_cnt++; if (st[2:0] !== 3'b110) $display("FAIL nop_stall_pattern: got %b want 110", st[2:0]); else pass_cnt++;
    total_cnt++; if (vl[2:0] !== 3'b001) $display("FAIL nop_inst_valid_pattern: got %b want 001", vl[2:0]); else pass_cnt++;
    total_cnt++; if (rq[2:0] !== 3'b100) $display("FAIL nop_req_pattern: got %b want 100", rq[2:0]); else pass_cnt++;
    total_cnt++; if (io_pc !== 32'h4) $display("FAIL nop_next_pc: got %h want 00000004", io_pc); else pass_cnt++;
    total_cnt++; if (io_stall_cnt !== 32'd2) $display("FAIL nop_stall_cnt: got %0d want 2", io_stall_cnt); else pass_cnt++;
  endtask

  task automatic test_jal_fwd();
    logic [15:0] st, rq, vl; logic ok;
    io_pc = 32'h10;
    drive_fetch(32'h0080_006F, 0, 0, st, rq, vl, ok);
    total_cnt++; if (vl[2:0] !== 3'b001) $display("FAIL jal_fwd_valid_pattern: got %b want 001", vl[2:0]); else pass_cnt++;
    total_cnt++; if (io_pc !== 32'h18) $display("FAIL jal_fwd_next_pc: got %h want 00000018", io_pc); else pass_cnt++;
  endtask

  task automatic test_jal_back();
    logic [15:0] st, rq, vl; logic ok;
    io_pc = 32'h20;
    drive_fetch(32'hFFDF_F0EF, 0, 0, st, rq, vl, ok);
    total_cnt++; if (io_pc !== 32'h1C) $display("FAIL jal_back_next_pc: got %h want 0000001c", io_pc); else pass_cnt++;
    total_cnt++; if (io_jal_en !== 1'b0 || io_imm !== 32'h0) $display("FAIL jal_back_cleared: got jal=%b imm=%h want 0/0", io_jal_en, io_imm); else pass_cnt++;
  endtask

  task automatic test_ready_hold();
    logic [15:0] st, rq, vl; logic ok;
    drive_fetch(32'h0040_0513, 5, 0, st, rq, vl, ok);
    total_cnt++; if (st[7:0] !== 8'b1111_1110) $display("FAIL hold_stall_pattern: got %b want 11111110", st[7:0]); else pass_cnt++;
    total_cnt++; if (rq[7:0] !== 8'b1111_1100) $display("FAIL hold_req_pattern: got %b want 11111100", rq[7:0]); else pass_cnt++;
    total_cnt++; if (ok !== 1'b1) $display("FAIL hold_addr_stable: got %b want 1", ok); else pass_cnt++;
    total_cnt++; if (io_fault !== 1'b0) $display("FAIL hold_fault: got %b want 0", io_fault); else pass_cnt++;
    total_cnt++; if (io_stall_cnt !== exp_stall) $display("FAIL hold_stall_cnt: got %0d want %0d", io_stall_cnt, exp_stall); else pass_cnt++;
    total_cnt++; if (io_pc !== 32'h20) $display("FAIL hold_next_pc: got %h want 00000020", io_pc); else pass_cnt++;
  endtask

  task automatic test_resp_at_timeout();
    logic [15:0] st, rq, vl; logic ok;
    drive_fetch(32'h00A0_0093, 0, 3, st, rq, vl, ok);
    total_cnt++; if (st[5:0] !== 6'b111110) $display("FAIL late_resp_stall_pattern: got %b want 111110", st[5:0]); else pass_cnt++;
    total_cnt++; if (vl[5:0] !== 6'b000001) $display("FAIL late_resp_valid_pattern: got %b want 000001", vl[5:0]); else pass_cnt++;
    total_cnt++; if (io_fault !== 1'b0) $display("FAIL late_resp_fault: got %b want 0", io_fault); else pass_cnt++;
    total_cnt++; if (io_pc !== 32'h24) $display("FAIL late_resp_next_pc: got %h want 00000024", io_pc); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] st, vl, rq; logic ok;
    logic [31:0] d, exp_pc;
    int rw, sw, n;
    for (int i = 0; i < 6; i++) begin
      d = $urandom;
      if (i % 2 == 1) d[6:0] = 7'h6F;
      d[21] = 1'b0;
      rw = $urandom_range(0, 2);
      sw = $urandom_range(0, 2);
      n  = rw + sw + 3;
      exp_pc = io_pc + (model_jal(d) ? model_imm(d) : 32'd4);
      drive_fetch(d, rw, sw, st, rq, vl, ok);
      total_cnt++; if (vl !== 16'd1) $display("FAIL b2b_valid_pattern[%0d]: got %b want 1", i, vl); else pass_cnt++;
      total_cnt++; if (st !== 16'((1 << n) - 2)) $display("FAIL b2b_stall_pattern[%0d]: got %b want %b", i, st, 16'((1 << n) - 2)); else pass_cnt++;
      total_cnt++; if (io_pc !== exp_pc) $display("FAIL b2b_next_pc[%0d]: got %h want %h", i, io_pc, exp_pc); else pass_cnt++;
    end
    total_cnt++; if (io_stall_cnt !== exp_stall) $display("FAIL b2b_stall_cnt: got %0d want %0d", io_stall_cnt, exp_stall); else pass_cnt++;
  endtask

  task automatic test_resp_outside_wait();
    io_mem_req_ready = 1'b0; io_mem_resp_valid = 1'b1; io_mem_resp_data = 32'h0080_006F;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      exp_stall++;
      total_cnt++; if (io_inst_valid !== 1'b0) $display("FAIL idle_resp_inst_valid[%0d]: got %b want 0", c, io_inst_valid); else pass_cnt++;
      total_cnt++; if (io_mem_req_valid !== 1'b1) $display("FAIL idle_resp_req_valid[%0d]: got %b want 1", c, io_mem_req_valid); else pass_cnt++;
    end
    io_mem_resp_valid = 1'b0;
    total_cnt++; if (io_stall_cnt !== exp_stall) $display("FAIL idle_resp_stall_cnt: got %0d want %0d", io_stall_cnt, exp_stall); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    io_pc = 32'h100; io_mem_req_ready = 1'b1;
    @(negedge clock);
    io_mem_req_ready = 1'b0; reset = 1'b1;
    @(negedge clock);
    total_cnt++; if (io_stall_en !== 1'b1 || io_mem_req_valid !== 1'b0) $display("FAIL mid_reset_outputs: got stall=%b req=%b want 1/0", io_stall_en, io_mem_req_valid); else pass_cnt++;
    reset = 1'b0; exp_stall = 0; io_mem_resp_valid = 1'b1; io_mem_resp_data = 32'hFFDF_F0EF;
    @(negedge clock);
    io_mem_resp_valid = 1'b0;
    total_cnt++; if (io_inst_valid !== 1'b0) $display("FAIL mid_reset_late_resp: got inst_valid=%b want 0", io_inst_valid); else pass_cnt++;
    total_cnt++; if (io_inst !== 32'h0000_0013) $display("FAIL mid_reset_inst: got %h want 00000013", io_inst); else pass_cnt++;
    total_cnt++; if (io_mem_req_valid !== 1'b1) $display("FAIL mid_reset_req_valid: got %b want 1", io_mem_req_valid); else pass_cnt++;
  endtask

  task automatic test_timeout();
    io_pc = 32'h40; io_mem_req_ready = 1'b1;
    @(negedge clock);
    io_mem_req_ready = 1'b0;
    repeat (3) @(negedge clock);
    total_cnt++; if (io_fault !== 1'b0) $display("FAIL timeout_early: got fault=%b want 0 after 3 WAIT cycles", io_fault); else pass_cnt++;
    @(negedge clock);
    total_cnt++; if (io_fault !== 1'b1) $display("FAIL timeout_fault: got %b want 1 after 4 WAIT cycles", io_fault); else pass_cnt++;
    total_cnt++; if (io_stall_en !== 1'b1 || io_mem_req_valid !== 1'b0) $display("FAIL timeout_outputs: got stall=%b req=%b want 1/0", io_stall_en, io_mem_req_valid); else pass_cnt++;
    io_mem_resp_valid = 1'b1; io_mem_resp_data = 32'h0080_006F; io_mem_req_ready = 1'b1;
    repeat (2) @(negedge clock);
    io_mem_resp_valid = 1'b0; io_mem_req_ready = 1'b0;
    total_cnt++; if (io_inst_valid !== 1'b0 || io_jal_en !== 1'b0) $display("FAIL timeout_late_resp: got valid=%b jal=%b want 0/0", io_inst_valid, io_jal_en); else pass_cnt++;
    total_cnt++; if (io_fault !== 1'b1 || io_stall_en !== 1'b1) $display("FAIL timeout_sticky: got fault=%b stall=%b want 1/1", io_fault, io_stall_en); else pass_cnt++;
    reset = 1'b1;
    @(negedge clock);
    total_cnt++; if (io_fault !== 1'b0) $display("FAIL timeout_reset_clears: got %b want 0", io_fault); else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_misaligned();
    reset = 1'b1; io_pc = 32'h2;
    repeat (2) @(negedge clock);
    reset = 1'b0; io_mem_req_ready = 1'b1;
    #1;
    total_cnt++; if (io_mem_req_valid !== 1'b0) $display("FAIL misalign_no_req: got %b want 0", io_mem_req_valid); else pass_cnt++;
    total_cnt++; if (io_fault !== 1'b0) $display("FAIL misalign_fault_early: got %b want 0", io_fault); else pass_cnt++;
    @(negedge clock);
    total_cnt++; if (io_fault !== 1'b1) $display("FAIL misalign_fault: got %b want 1", io_fault); else pass_cnt++;
    total_cnt++; if (io_stall_en !== 1'b1 || io_mem_req_valid !== 1'b0) $display("FAIL misalign_outputs: got stall=%b req=%b want 1/0", io_stall_en, io_mem_req_valid); else pass_cnt++;
    @(negedge clock);
    io_mem_req_ready = 1'b0;
    total_cnt++; if (io_stall_cnt !== 32'd2) $display("FAIL misalign_stall_cnt: got %0d want 2", io_stall_cnt); else pass_cnt++;
    total_cnt++; if (io_fault !== 1'b1 || io_inst_valid !== 1'b0) $display("FAIL misalign_sticky: got fault=%b valid=%b want 1/0", io_fault, io_inst_valid); else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1; io_pc = 32'h0; io_mem_req_ready = 1'b0;
    io_mem_resp_valid = 1'b0; io_mem_resp_data = 32'h0;
    @(negedge clock);
    test_reset();
    test_nop();
    test_jal_fwd();
    test_jal_back();
    test_ready_hold();
    test_resp_at_timeout();
    test_back_to_back();
    test_resp_outside_wait();
    test_reset_mid();
    test_timeout();
    test_misaligned();
    @(negedge clock);
    total_cnt++; if (sb_q.size() != 0) $display("FAIL sb_drained: got %0d pending want 0", sb_q.size()); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
